// File: rtl/rcv_pkg.sv
// rcv_pkg: shared constants for the full-speed USB receiver.
//   - PID codes and PID classification helper
//   - SYNC pattern, FSM state encodings, default payload limit
package rcv_pkg;

  localparam int         USB_FS_MHZ      = 12;
  localparam int         MAX_PAYLOAD_DEF = 64;
  localparam logic [7:0] SYNC_BYTE       = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SYNC     = 3'd1;
  localparam logic [2:0] ST_PID      = 3'd2;
  localparam logic [2:0] ST_TOKEN    = 3'd3;
  localparam logic [2:0] ST_HSHAKE   = 3'd4;
  localparam logic [2:0] ST_DATA     = 3'd5;
  localparam logic [2:0] ST_ERR_WAIT = 3'd6;
  localparam logic [2:0] ST_EOP_WAIT = 3'd7;

  typedef enum logic [1:0] {
    PKT_TOKEN,
    PKT_DATA,
    PKT_HSHAKE,
    PKT_NONE
  } pkt_class_t;

  function automatic pkt_class_t pid_class(input logic [3:0] pid);
    case (pid)
      PID_OUT, PID_IN:             pid_class = PKT_TOKEN;
      PID_DATA0, PID_DATA1:        pid_class = PKT_DATA;
      PID_ACK, PID_NAK, PID_STALL: pid_class = PKT_HSHAKE;
      default:                     pid_class = PKT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rcv_phy.sv
// rcv_phy: line front end of the USB receiver.
//   Synchronizes D+/D-, re-times the bit clock on every D+ edge, samples at
//   mid-bit, NRZI-decodes, detects SE0 (EOP) and assembles bytes LSB-first.
// Build option: RCV_BIT_UNSTUFF_EN drops the bit following six decoded 1s
//   and flags stuff_err if that bit is a 1.
// Ports:
//   clk, n_rst      clock, synchronous active-high reset
//   d_plus, d_minus raw asynchronous line pair
//   clr             restart byte assembly (packet start)
//   bit_valid/rx_bit one-cycle decoded data bit
//   byte_done       one-cycle pulse, rx_byte holds the completed byte
//   eop             one-cycle pulse for an SE0 sample
//   stuff_err       stuffing violation pulse
//   k_start         first J->K transition (D+ falls, D- high)
//   line_j          line currently at J
//   bit_cnt_nz      a partial byte is in the shift register
module rcv_phy
  import rcv_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       clr,
  output logic       bit_valid,
  output logic       rx_bit,
  output logic       byte_done,
  output logic       eop,
  output logic       stuff_err,
  output logic       k_start,
  output logic       line_j,
  output logic       bit_cnt_nz,
  output logic [7:0] rx_byte
);

  // Bit period is not an integer number of clocks; every third interval is
  // one clock longer so the sample point stays centred between edges.
  localparam int         BIT_CLKS   = CLK_FREQ_MHZ / USB_FS_MHZ;
  localparam logic [3:0] LOAD_HALF  = 4'(BIT_CLKS / 2 - 1);
  localparam logic [3:0] LOAD_SHORT = 4'(BIT_CLKS - 1);
  localparam logic [3:0] LOAD_LONG  = 4'(BIT_CLKS);

  logic       dp_s1, dp_s2, dm_s1, dm_s2, dp_prev, prev_level;
  logic [3:0] tmr;
  logic [1:0] phase;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       dp_edge, sample, se0, nrzi_bit, keep_bit;

  assign dp_edge    = dp_s2 ^ dp_prev;
  assign sample     = !dp_edge && (tmr == 4'd0);
  assign se0        = !dp_s2 && !dm_s2;
  assign nrzi_bit   = (dp_s2 == prev_level);
  assign k_start    = dp_edge && !dp_s2 && dm_s2;
  assign line_j     = dp_s2 && !dm_s2;
  assign bit_cnt_nz = (bit_cnt != 3'd0);
  assign rx_byte    = shreg;

`ifdef RCV_BIT_UNSTUFF_EN
  logic [2:0] ones;
  assign keep_bit = (ones != 3'd6);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      ones      <= 3'd0;
      stuff_err <= 1'b0;
    end else begin
      stuff_err <= 1'b0;
      if (clr) begin
        ones <= 3'd0;
      end else if (sample && !se0) begin
        if (ones == 3'd6) begin
          ones      <= 3'd0;
          stuff_err <= nrzi_bit;
        end else if (nrzi_bit) begin
          ones <= ones + 3'd1;
        end else begin
          ones <= 3'd0;
        end
      end
    end
  end
`else
  assign keep_bit  = 1'b1;
  assign stuff_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (n_rst) begin
      dp_s1      <= 1'b1;
      dp_s2      <= 1'b1;
      dp_prev    <= 1'b1;
      dm_s1      <= 1'b0;
      dm_s2      <= 1'b0;
      prev_level <= 1'b1;
      tmr        <= 4'd0;
      phase      <= 2'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      bit_valid  <= 1'b0;
      rx_bit     <= 1'b0;
      byte_done  <= 1'b0;
      eop        <= 1'b0;
    end else begin
      dp_s1     <= d_plus;
      dp_s2     <= dp_s1;
      dm_s1     <= d_minus;
      dm_s2     <= dm_s1;
      dp_prev   <= dp_s2;
      bit_valid <= 1'b0;
      byte_done <= 1'b0;
      eop       <= 1'b0;

      if (dp_edge) begin
        tmr   <= LOAD_HALF;
        phase <= 2'd0;
      end else if (tmr == 4'd0) begin
        tmr   <= (phase == 2'd2) ? LOAD_LONG : LOAD_SHORT;
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end else begin
        tmr <= tmr - 4'd1;
      end

      if (sample) begin
        if (se0) begin
          eop <= 1'b1;
        end else begin
          prev_level <= dp_s2;
          if (keep_bit) begin
            bit_valid <= 1'b1;
            rx_bit    <= nrzi_bit;
            shreg     <= {nrzi_bit, shreg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            byte_done <= (bit_cnt == 3'd7);
          end
        end
      end

      if (clr) bit_cnt <= 3'd0;
    end
  end

endmodule

// File: rtl/rcv_block.sv
// rcv_block: full-speed USB device receiver (top).
//   Checks SYNC/PID, validates token address/endpoint, streams data payload
//   to the RX FIFO through a two-byte hold pipeline that strips CRC16.
// Build option: RCV_BIT_UNSTUFF_EN enables bit unstuffing in rcv_phy.
// Ports:
//   clk, n_rst          clock, synchronous active-high reset
//   d_plus, d_minus     raw USB line pair
//   buffer_occupancy    RX FIFO byte count
//   rx_error            last packet malformed/rejected
//   rx_transfer_active  packet in progress
//   flush               one-cycle FIFO clear (data PID seen)
//   rx_data_ready       last data packet wrote at least one byte
//   rx_packet           last accepted PID, 0 if invalid
//   w_enable, rcv_data  FIFO write strobe and byte
//
// state     | meaning
// IDLE      | line idle, waiting for first K
// SYNC      | checking sync bits serially
// PID       | waiting for PID byte
// TOKEN     | collecting address/endpoint bytes
// HSHAKE    | handshake, no bytes expected
// DATA      | payload streaming through hold pipeline
// ERR_WAIT  | packet rejected, ignore until EOP
// EOP_WAIT  | EOP seen, wait for J
module rcv_block
  import rcv_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'd1,
  parameter logic [3:0] DEV_ENDP     = 4'd1,
  parameter int         MAX_PAYLOAD  = MAX_PAYLOAD_DEF,
  parameter int         CLK_FREQ_MHZ = 100
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic [6:0] buffer_occupancy,
  output logic       rx_error,
  output logic       rx_transfer_active,
  output logic       flush,
  output logic       rx_data_ready,
  output logic [3:0] rx_packet,
  output logic       w_enable,
  output logic [7:0] rcv_data
);

  localparam logic [6:0] MAX_P7 = 7'(MAX_PAYLOAD);

  logic       bit_valid, rx_bit, byte_done, eop, stuff_err, k_start, line_j, bit_cnt_nz;
  logic [7:0] rx_byte;
  logic       clr;

  logic [2:0] state;
  logic [2:0] sync_idx;
  logic [1:0] tok_cnt;
  logic [7:0] tok_b0, tok_b1;
  logic [7:0] hold0, hold1;
  logic [1:0] hcnt;
  logic [6:0] pay_cnt;

  pkt_class_t pcls;
  logic       pid_ok, tok_match, write_blocked, receiving;

  rcv_phy #(.CLK_FREQ_MHZ(CLK_FREQ_MHZ)) u_phy (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .clr       (clr),
    .bit_valid (bit_valid),
    .rx_bit    (rx_bit),
    .byte_done (byte_done),
    .eop       (eop),
    .stuff_err (stuff_err),
    .k_start   (k_start),
    .line_j    (line_j),
    .bit_cnt_nz(bit_cnt_nz),
    .rx_byte   (rx_byte)
  );

  assign clr           = (state == ST_IDLE) && k_start;
  assign pcls          = pid_class(rx_byte[3:0]);
  assign pid_ok        = (rx_byte[7:4] == ~rx_byte[3:0]) && (pcls != PKT_NONE);
  // tok_cnt saturates at 3, so any count other than exactly 2 fails here
  assign tok_match     = (tok_cnt == 2'd2) && (tok_b0[6:0] == DEV_ADDR) &&
                         ({tok_b1[2:0], tok_b0[7]} == DEV_ENDP);
  assign write_blocked = (pay_cnt == MAX_P7) || (buffer_occupancy >= MAX_P7);
  assign receiving     = (state == ST_SYNC) || (state == ST_PID) || (state == ST_TOKEN) ||
                         (state == ST_HSHAKE) || (state == ST_DATA);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state              <= ST_IDLE;
      sync_idx           <= 3'd0;
      tok_cnt            <= 2'd0;
      tok_b0             <= 8'd0;
      tok_b1             <= 8'd0;
      hold0              <= 8'd0;
      hold1              <= 8'd0;
      hcnt               <= 2'd0;
      pay_cnt            <= 7'd0;
      rx_error           <= 1'b0;
      rx_transfer_active <= 1'b0;
      flush              <= 1'b0;
      rx_data_ready      <= 1'b0;
      rx_packet          <= 4'd0;
      w_enable           <= 1'b0;
      rcv_data           <= 8'd0;
    end else begin
      w_enable <= 1'b0;
      flush    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (k_start) begin
            state              <= ST_SYNC;
            sync_idx           <= 3'd0;
            rx_transfer_active <= 1'b1;
            rx_error           <= 1'b0;
            rx_data_ready      <= 1'b0;
            rx_packet          <= 4'd0;
          end
        end

        ST_SYNC: begin
          if (eop) begin
            rx_error           <= 1'b1;
            rx_transfer_active <= 1'b0;
            state              <= ST_EOP_WAIT;
          end else if (bit_valid) begin
            if (rx_bit != SYNC_BYTE[sync_idx]) begin
              rx_error <= 1'b1;
              state    <= ST_ERR_WAIT;
            end else if (sync_idx == 3'd7) begin
              state <= ST_PID;
            end
            sync_idx <= sync_idx + 3'd1;
          end
        end

        ST_PID: begin
          if (eop) begin
            rx_error           <= 1'b1;
            rx_transfer_active <= 1'b0;
            state              <= ST_EOP_WAIT;
          end else if (byte_done) begin
            if (pid_ok) begin
              rx_packet <= rx_byte[3:0];
              tok_cnt   <= 2'd0;
              hcnt      <= 2'd0;
              pay_cnt   <= 7'd0;
              case (pcls)
                PKT_TOKEN: state <= ST_TOKEN;
                PKT_DATA: begin
                  state <= ST_DATA;
                  flush <= 1'b1;
                end
                default:   state <= ST_HSHAKE;
              endcase
            end else begin
              rx_packet <= 4'd0;
              rx_error  <= 1'b1;
              state     <= ST_ERR_WAIT;
            end
          end
        end

        ST_TOKEN: begin
          if (eop) begin
            rx_transfer_active <= 1'b0;
            state              <= ST_EOP_WAIT;
            if (!tok_match || bit_cnt_nz) rx_error <= 1'b1;
          end else if (byte_done) begin
            if (tok_cnt == 2'd0) tok_b0 <= rx_byte;
            if (tok_cnt == 2'd1) tok_b1 <= rx_byte;
            if (tok_cnt != 2'd3) tok_cnt <= tok_cnt + 2'd1;
          end
        end

        ST_HSHAKE: begin
          if (eop) begin
            rx_transfer_active <= 1'b0;
            state              <= ST_EOP_WAIT;
            if (bit_cnt_nz) rx_error <= 1'b1;
          end else if (byte_done) begin
            rx_error <= 1'b1;
            state    <= ST_ERR_WAIT;
          end
        end

        ST_DATA: begin
          if (eop) begin
            rx_transfer_active <= 1'b0;
            state              <= ST_EOP_WAIT;
            rx_data_ready      <= (pay_cnt != 7'd0);
            if ((hcnt != 2'd2) || bit_cnt_nz) rx_error <= 1'b1;
          end else if (byte_done) begin
            // The two most recent bytes stay held; at EOP they are the CRC16.
            if (hcnt == 2'd2) begin
              if (write_blocked) begin
                rx_error <= 1'b1;
              end else begin
                rcv_data <= hold0;
                w_enable <= 1'b1;
                pay_cnt  <= pay_cnt + 7'd1;
              end
              hold0 <= hold1;
              hold1 <= rx_byte;
            end else if (hcnt == 2'd1) begin
              hold1 <= rx_byte;
              hcnt  <= 2'd2;
            end else begin
              hold0 <= rx_byte;
              hcnt  <= 2'd1;
            end
          end
        end

        ST_ERR_WAIT: begin
          if (eop) begin
            rx_transfer_active <= 1'b0;
            state              <= ST_IDLE;
          end
        end

        ST_EOP_WAIT: begin
          if (line_j) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase

      if (stuff_err && receiving) begin
        rx_error <= 1'b1;
        state    <= ST_ERR_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_rcv_block.sv
// tb_rcv_block: directed bench for rcv_block. Drives NRZI-encoded packets
// onto D+/D- at 8/8/9 clocks per bit and checks status after each EOP.
module tb_rcv_block;

  logic       tb_clk;
  logic       n_rst;
  logic       d_plus, d_minus;
  logic [6:0] occ;
  logic       rx_error, rx_transfer_active, flush, rx_data_ready, w_enable;
  logic [3:0] rx_packet;
  logic [7:0] rcv_data;

  int n_pass, n_fail, n_total;
  int wr_count, fl_count;
  int wr_base, fl_base;
  int bph;
  logic cur;

  rcv_block dut (
    .clk               (tb_clk),
    .n_rst             (n_rst),
    .d_plus            (d_plus),
    .d_minus           (d_minus),
    .buffer_occupancy  (occ),
    .rx_error          (rx_error),
    .rx_transfer_active(rx_transfer_active),
    .flush             (flush),
    .rx_data_ready     (rx_data_ready),
    .rx_packet         (rx_packet),
    .w_enable          (w_enable),
    .rcv_data          (rcv_data)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // FIFO occupancy model plus write/flush counters
  initial begin
    occ      = 7'd0;
    wr_count = 0;
    fl_count = 0;
  end
  always @(posedge tb_clk) begin
    if (flush) occ <= 7'd0;
    else if (w_enable) occ <= occ + 7'd1;
    if (w_enable) wr_count <= wr_count + 1;
    if (flush) fl_count <= fl_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    int n;
    n   = (bph == 2) ? 9 : 8;
    bph = (bph == 2) ? 0 : bph + 1;
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic drive_line(input logic dp, input logic dm);
    d_plus  = dp;
    d_minus = dm;
    bit_time();
  endtask

  task automatic send_bit(input logic b);
    if (!b) cur = ~cur;
    drive_line(cur, ~cur);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_eop();
    drive_line(1'b0, 1'b0);
    drive_line(1'b0, 1'b0);
    cur = 1'b1;
    drive_line(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_line(1'b1, 1'b0);
  endtask

  task automatic mark();
    wr_base = wr_count;
    fl_base = fl_count;
  endtask

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    bph = 0; cur = 1'b1;
    wr_base = 0; fl_base = 0;
    n_rst = 1'b1; d_plus = 1'b1; d_minus = 1'b0;
    repeat (4) @(negedge tb_clk);
    n_rst = 1'b0;
    @(negedge tb_clk);
    chk("rst_error", rx_error, 0);
    chk("rst_active", rx_transfer_active, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ready", rx_data_ready, 0);
    chk("rst_packet", rx_packet, 0);
    chk("rst_wen", w_enable, 0);
    chk("rst_data", rcv_data, 0);
    for (int i = 0; i < 3; i++) drive_line(1'b1, 1'b0);

    // IN token, matching address/endpoint
    mark();
    send_byte(8'h80); send_byte(8'h69);
    chk("in_active_mid", rx_transfer_active, 1);
    send_byte(8'h81); send_byte(8'h60); send_eop();
    chk("in_packet", rx_packet, 4'b1001);
    chk("in_error", rx_error, 0);
    chk("in_ready", rx_data_ready, 0);
    chk("in_active_end", rx_transfer_active, 0);
    chk("in_writes", wr_count - wr_base, 0);

    // IN token, wrong address
    send_byte(8'h80); send_byte(8'h69); send_byte(8'hCB); send_byte(8'h50); send_eop();
    chk("in_bad_packet", rx_packet, 4'b1001);
    chk("in_bad_error", rx_error, 1);

    // DATA0 three-byte payload
    mark();
    send_byte(8'h80); send_byte(8'hC3);
    send_byte(8'hAD); send_byte(8'hD7); send_byte(8'h2C);
    send_byte(8'h80); send_byte(8'h0D); send_eop();
    chk("d3_writes", wr_count - wr_base, 3);
    chk("d3_flush", fl_count - fl_base, 1);
    chk("d3_data", rcv_data, 8'h2C);
    chk("d3_ready", rx_data_ready, 1);
    chk("d3_error", rx_error, 0);
    chk("d3_packet", rx_packet, 4'b0011);

    // DATA0 25 bytes
    mark();
    send_byte(8'h80); send_byte(8'hC3);
    for (int i = 0; i < 25; i++) send_byte(8'hBC);
    send_byte(8'h80); send_byte(8'h0D); send_eop();
    chk("d25_writes", wr_count - wr_base, 25);
    chk("d25_data", rcv_data, 8'hBC);
    chk("d25_ready", rx_data_ready, 1);
    chk("d25_error", rx_error, 0);

    // DATA0 65 bytes: last payload byte overflows
    mark();
    send_byte(8'h80); send_byte(8'hC3);
    for (int i = 0; i < 65; i++) send_byte(8'hBC);
    send_byte(8'h80); send_byte(8'h0D); send_eop();
    chk("d65_writes", wr_count - wr_base, 64);
    chk("d65_error", rx_error, 1);
    chk("d65_ready", rx_data_ready, 1);
    chk("d65_data", rcv_data, 8'hBC);

    // DATA0 with a stray bit: EOP lands mid-byte
    mark();
    send_byte(8'h80); send_byte(8'hC3); send_byte(8'h0B);
    send_bit(1'b0);
    send_byte(8'h80); send_byte(8'h0D); send_eop();
    chk("dbit_writes", wr_count - wr_base, 1);
    chk("dbit_error", rx_error, 1);
    chk("dbit_ready", rx_data_ready, 1);
    chk("dbit_data", rcv_data, 8'h0B);

    // DATA0 with a single byte
    mark();
    send_byte(8'h80); send_byte(8'hC3); send_byte(8'h0B); send_eop();
    chk("d1_writes", wr_count - wr_base, 0);
    chk("d1_error", rx_error, 1);
    chk("d1_ready", rx_data_ready, 0);
    chk("d1_data_hold", rcv_data, 8'h0B);

    // Handshakes
    send_byte(8'h80); send_byte(8'hD2); send_eop();
    chk("ack_packet", rx_packet, 4'b0010);
    chk("ack_error", rx_error, 0);
    chk("ack_ready", rx_data_ready, 0);
    send_byte(8'h80); send_byte(8'h5A); send_eop();
    chk("nak_packet", rx_packet, 4'b1010);
    chk("nak_error", rx_error, 0);
    send_byte(8'h80); send_byte(8'h1E); send_eop();
    chk("stall_packet", rx_packet, 4'b1110);
    chk("stall_error", rx_error, 0);

    // Bad sync followed by what looks like a data packet
    mark();
    send_byte(8'h20); send_byte(8'hC3);
    send_byte(8'hAD); send_byte(8'hD7); send_byte(8'h2C); send_byte(8'h80);
    send_eop();
    chk("sync_error", rx_error, 1);
    chk("sync_packet", rx_packet, 0);
    chk("sync_writes", wr_count - wr_base, 0);
    chk("sync_flush", fl_count - fl_base, 0);
    chk("sync_active", rx_transfer_active, 0);

    // Invalid PID
    send_byte(8'h80); send_byte(8'hF0); send_eop();
    chk("pidf0_packet", rx_packet, 0);
    chk("pidf0_error", rx_error, 1);

    // Reset in the middle of a data packet
    send_byte(8'h80); send_byte(8'hC3);
    send_byte(8'hAD); send_byte(8'hD7); send_byte(8'h2C);
    if (cur == 1'b0) send_bit(1'b0);
    chk("abort_active_pre", rx_transfer_active, 1);
    n_rst = 1'b1;
    repeat (2) @(negedge tb_clk);
    n_rst = 1'b0;
    @(negedge tb_clk);
    chk("abort_active", rx_transfer_active, 0);
    chk("abort_packet", rx_packet, 0);
    chk("abort_data", rcv_data, 0);
    chk("abort_error", rx_error, 0);
    send_eop();
    chk("abort_post_error", rx_error, 0);
    chk("abort_post_active", rx_transfer_active, 0);
    chk("abort_post_ready", rx_data_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
